// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: FSM encoding and the byte driven on MISO
// when no reply byte has been supplied.
package spi_target_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [7:0] IDLE_FILL = 8'hFF;

endpackage

// File: rtl/spi_target_pin_sync.sv
// Pin synchronizer: SYNC_STAGES flop chain plus one history flop, with
// registered single-cycle rise/fall pulses aligned to the delayed level.
module spi_pin_sync
    import spi_target_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{IDLE_LEVEL}};
            hist  <= IDLE_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            hist  <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~hist;
            fall  <= ~chain[SYNC_STAGES-1] & hist;
        end
    end

    // level is taken from the history flop so it lines up with the pulses
    assign level = hist;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, oversampled in the clk domain. Sticky error flags are
// present only when SPI_TARGET_ERR_FLAGS_EN is defined; otherwise tied low.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | CS deasserted (or just reset); MISO low, SCLK edges ignored
// ST_ACTIVE | frame in progress; shift on SCLK edges, reload per byte
module spi_target
    import spi_target_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       busy,
    output logic       err_overrun,
    output logic       err_underrun,
    output logic       err_abort,
    input  logic       err_clear
);

    logic cs_n_s, cs_fall, cs_rise;
    logic sclk_rise, sclk_fall, mosi_s;
    logic unused_sclk_level, unused_mosi_rise, unused_mosi_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin(spi_clk),
        .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .pin(spi_mosi),
        .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .pin(spi_cs_n),
        .level(cs_n_s), .rise(cs_rise), .fall(cs_fall)
    );

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh;
    logic [6:0] rx_sh;
    logic [7:0] hold;
    logic       hold_full;
    logic       active, byte_done, do_load, hold_wr;
    logic [7:0] load_val;

    assign active    = (state == ST_ACTIVE);
    assign byte_done = active && !cs_rise && sclk_fall && (bit_cnt == 3'd7);
    assign do_load   = (!active && cs_fall) || byte_done;
    assign hold_wr   = tx_valid && !hold_full;
    assign load_val  = hold_full ? hold : IDLE_FILL;
    assign tx_ready  = !hold_full;
    assign busy      = !cs_n_s;

    // A load from a full register wins; a write only lands when it is empty,
    // which includes a load cycle that had to fall back to IDLE_FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold      <= 8'h00;
        end else if (do_load && hold_full) begin
            hold_full <= 1'b0;
        end else if (hold_wr) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (byte_done) begin
            rx_data  <= {rx_sh, mosi_s};
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            tx_sh    <= 8'h00;
            rx_sh    <= 7'h00;
            spi_miso <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    spi_miso <= 1'b0;
                    bit_cnt  <= 3'd0;
                    if (cs_fall) begin
                        tx_sh <= load_val;
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state    <= ST_IDLE;
                        bit_cnt  <= 3'd0;
                        spi_miso <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            spi_miso <= tx_sh[7];
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                        end
                        if (sclk_fall) begin
                            rx_sh   <= {rx_sh[5:0], mosi_s};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            tx_sh <= load_val;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SPI_TARGET_ERR_FLAGS_EN
    logic ovr_set, und_set, abt_set;

    assign ovr_set = byte_done && rx_valid && !rx_ack;
    assign und_set = do_load && !hold_full;
    assign abt_set = active && cs_rise && (bit_cnt != 3'd0);

    // a setting event in the same cycle as err_clear leaves the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            if (ovr_set)        err_overrun  <= 1'b1;
            else if (err_clear) err_overrun  <= 1'b0;
            if (und_set)        err_underrun <= 1'b1;
            else if (err_clear) err_underrun <= 1'b0;
            if (abt_set)        err_abort    <= 1'b1;
            else if (err_clear) err_abort    <= 1'b0;
        end
    end
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;
    assign err_overrun      = 1'b0;
    assign err_underrun     = 1'b0;
    assign err_abort        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a bit-banged SPI master drives the pins,
// expected RX/MISO bytes are queued and checked by two monitor processes.
module tb_spi_target;

    localparam int SYNC = 2;
    localparam int HALF = 6;
`ifdef SPI_TARGET_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
    logic       spi_miso;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ack, busy;
    logic       err_overrun, err_underrun, err_abort;
    logic       err_clear = 1'b0;

    logic       wr_valid = 1'b0, late_valid = 1'b0;
    logic [7:0] wr_data = 8'h00, late_data = 8'h00;
    logic       mon_ack = 1'b0, man_ack = 1'b0, auto_ack = 1'b0;

    assign tx_valid = wr_valid | late_valid;
    assign tx_data  = late_valid ? late_data : wr_data;
    assign rx_ack   = mon_ack | man_ack;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] obs_miso[$];

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .busy(busy),
        .err_overrun(err_overrun), .err_underrun(err_underrun), .err_abort(err_abort),
        .err_clear(err_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // RX monitor: compares on each new rx_valid, optionally acknowledges it
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid && !prev_valid) begin
                if (exp_rx.size() == 0) check("rx_queue_empty", exp_rx.size(), 1);
                else                    check("rx_data", rx_data, exp_rx.pop_front());
                mon_ack = auto_ack;
            end else begin
                mon_ack = 1'b0;
            end
            prev_valid = rx_valid;
        end
    end

    // MISO monitor: bytes captured by the master against the expected queue
    initial begin
        logic [7:0] got;
        forever begin
            @(negedge clk);
            while (obs_miso.size() > 0) begin
                got = obs_miso.pop_front();
                if (exp_miso.size() == 0) check("miso_queue_empty", exp_miso.size(), 1);
                else                      check("miso_byte", got, exp_miso.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic write_tx(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", tx_ready, 1);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk) spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk) spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk) err_clear = 1'b1;
        @(negedge clk) err_clear = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk) man_ack = 1'b1;
        @(negedge clk) man_ack = 1'b0;
    endtask

    // Master byte: MOSI changes with rising SCLK, MISO sampled just before fall.
    // ack_last/tx_last drive rx_ack/tx_valid in the DUT's byte-completion cycle.
    task automatic xfer(input logic [7:0] b, input int nbits, input logic ack_last,
                        input logic tx_last, input logic [7:0] tx_byte);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            spi_clk  = 1'b1;
            spi_mosi = b[i];
            repeat (HALF - 1) @(negedge clk);
            got = {got[6:0], spi_miso};
            @(negedge clk);
            spi_clk = 1'b0;
            if (i == 0 && (ack_last || tx_last)) begin
                repeat (SYNC + 1) @(negedge clk);
                man_ack    = ack_last;
                late_valid = tx_last;
                late_data  = tx_byte;
                @(negedge clk);
                man_ack    = 1'b0;
                late_valid = 1'b0;
                repeat (HALF - SYNC - 3) @(negedge clk);
            end else begin
                repeat (HALF - 1) @(negedge clk);
            end
        end
        if (nbits == 8) obs_miso.push_back(got);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miso", spi_miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {err_overrun, err_underrun, err_abort}, 3'b000);

        // single byte
        write_tx(8'hA5);
        check("t1_tx_ready_full", tx_ready, 0);
        exp_miso.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        cs_low();
        check("t1_busy", busy, 1);
        xfer(8'h3C, 8, 1'b0, 1'b0, 8'h00);
        cs_high();
        check("t1_busy_off", busy, 0);
        check("t1_tx_ready_back", tx_ready, 1);
        repeat (5) @(negedge clk);
        check("t1_rx_valid_held", rx_valid, 1);
        pulse_ack();
        check("t1_rx_valid_acked", rx_valid, 0);
        check("t1_underrun", err_underrun, ERR_EN);
        check("t1_abort", err_abort, 0);
        pulse_clear();
        check("t1_cleared", err_underrun, 0);

        // back-to-back with hold refills
        auto_ack = 1'b1;
        exp_rx.push_back(8'h01); exp_rx.push_back(8'h80); exp_rx.push_back(8'hFF);
        exp_miso.push_back(8'h11); exp_miso.push_back(8'h22); exp_miso.push_back(8'h33);
        write_tx(8'h11);
        cs_low();
        fork
            begin
                xfer(8'h01, 8, 1'b0, 1'b0, 8'h00);
                xfer(8'h80, 8, 1'b0, 1'b0, 8'h00);
                xfer(8'hFF, 8, 1'b0, 1'b0, 8'h00);
            end
            begin
                write_tx(8'h22);
                write_tx(8'h33);
            end
        join
        cs_high();
        check("t2_overrun", err_overrun, 0);
        check("t2_underrun", err_underrun, ERR_EN);
        pulse_clear();

        // underrun and overrun
        auto_ack = 1'b0;
        exp_rx.push_back(8'hC3);
        exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
        cs_low();
        xfer(8'hC3, 8, 1'b0, 1'b0, 8'h00);
        xfer(8'h7E, 8, 1'b0, 1'b0, 8'h00);
        cs_high();
        check("t3_rx_data_overwrite", rx_data, 8'h7E);
        check("t3_rx_valid", rx_valid, 1);
        check("t3_underrun", err_underrun, ERR_EN);
        check("t3_overrun", err_overrun, ERR_EN);
        pulse_clear();
        check("t3_clear", {err_underrun, err_overrun}, 2'b00);
        pulse_ack();
        check("t3_rx_valid_acked", rx_valid, 0);

        // abort after 5 bits, then a clean frame
        cs_low();
        xfer(8'hF0, 5, 1'b0, 1'b0, 8'h00);
        cs_high();
        check("t4_rx_valid", rx_valid, 0);
        check("t4_abort", err_abort, ERR_EN);
        pulse_clear();
        check("t4_abort_clear", err_abort, 0);
        auto_ack = 1'b1;
        exp_rx.push_back(8'h5A);
        exp_miso.push_back(8'hFF);
        cs_low();
        xfer(8'h5A, 8, 1'b0, 1'b0, 8'h00);
        cs_high();
        check("t4_abort_after", err_abort, 0);

        // reset in mid-frame
        write_tx(8'h9C);
        cs_low();
        xfer(8'hF0, 3, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        spi_cs_n = 1'b1;
        @(negedge clk);
        check("t5_miso", spi_miso, 0);
        check("t5_tx_ready", tx_ready, 1);
        check("t5_rx_data", rx_data, 8'h00);
        check("t5_rx_valid", rx_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_errs", {err_overrun, err_underrun, err_abort}, 3'b000);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        write_tx(8'h66);
        exp_rx.push_back(8'hE7);
        exp_miso.push_back(8'h66);
        cs_low();
        xfer(8'hE7, 8, 1'b0, 1'b0, 8'h00);
        cs_high();
        pulse_clear();

        // rx_ack in the completion cycle
        auto_ack = 1'b0;
        exp_rx.push_back(8'h12);
        exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
        cs_low();
        xfer(8'h12, 8, 1'b0, 1'b0, 8'h00);
        xfer(8'h34, 8, 1'b1, 1'b0, 8'h00);
        cs_high();
        check("t6_rx_data", rx_data, 8'h34);
        check("t6_rx_valid", rx_valid, 1);
        check("t6_no_overrun", err_overrun, 0);
        pulse_ack();
        check("t6_rx_valid_acked", rx_valid, 0);

        // tx write in a load cycle with hold empty
        auto_ack = 1'b1;
        exp_rx.push_back(8'hA1); exp_rx.push_back(8'hB2); exp_rx.push_back(8'hC3);
        exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF); exp_miso.push_back(8'h77);
        cs_low();
        xfer(8'hA1, 8, 1'b0, 1'b1, 8'h77);
        check("t6_tx_ready_taken", tx_ready, 0);
        xfer(8'hB2, 8, 1'b0, 1'b0, 8'h00);
        check("t6_tx_ready_loaded", tx_ready, 1);
        xfer(8'hC3, 8, 1'b0, 1'b0, 8'h00);
        cs_high();

        repeat (20) @(negedge clk);
        check("rx_queue_drained", exp_rx.size(), 0);
        check("miso_queue_drained", exp_miso.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

- SPI responder (target) for the duckcpu SPI link.
- Accepts mode-0 style transfers from the on-chip SPI master core (or an external master): SCLK idles low, MOSI changes on rising SCLK, bits are sampled on falling SCLK, MSB first, 8-bit frames.
- Oversamples SCLK/MOSI/CS_N in the system clock domain and hands received bytes to the core through a valid/ack pair.
- Takes reply bytes through a one-entry valid/ready holding register.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_clk`, `spi_mosi` and `spi_cs_n`; legal range ≥2.
- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `spi_clk` input 1: SCLK from the master, asynchronous.
- `spi_mosi` input 1: data from the master, asynchronous.
- `spi_cs_n` input 1: frame select, active low, asynchronous.
- `spi_miso` output 1: data to the master, registered.
- `tx_data` input 8: reply byte.
- `tx_valid` input 1: `tx_data` offered.
- `tx_ready` output 1: holding register empty; a write is accepted when `tx_valid && tx_ready`.
- `rx_data` output 8: last received byte.
- `rx_valid` output 1: `rx_data` holds an unacknowledged byte.
- `rx_ack` input 1: consumer takes `rx_data`; clears `rx_valid`.
- `busy` output 1: synchronized CS is asserted.
- `err_overrun`, `err_underrun`, `err_abort` output 1 each: sticky error flags (see Configuration).
- `err_clear` input 1: clears all sticky flags.

## Operation
- **Sync and edge detect:**
  - Each pin passes through a `SYNC_STAGES` flop chain, then one history flop.
  - `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise` are single-cycle pulses derived from the synchronized value and the history flop.
  - MOSI uses the synchronized copy, which carries the same delay as SCLK.
- **State machine:**
  - IDLE:
    - Entered on reset or `cs_rise`.
    - `spi_miso`=0, `bit_cnt`=0, SCLK edges ignored.
    - `cs_fall` → load shift register, go to ACTIVE.
  - ACTIVE, on `sclk_rise`: `spi_miso` <= `tx_sh[7]`; `tx_sh` <= {`tx_sh[6:0]`, 0}.
  - ACTIVE, on `sclk_fall`:
    - `rx_sh` <= {`rx_sh[6:0]`, `mosi_s`}.
    - `bit_cnt` increments as a 3-bit counter and wraps 7→0.
    - When `bit_cnt` was 7, the byte is complete: `rx_data` <= assembled byte, `rx_valid` <= 1, shift register reloaded for the next back-to-back byte.
  - ACTIVE, on `cs_rise`:
    - Go to IDLE.
    - If `bit_cnt`≠0, the partial byte is discarded and `err_abort` is set.
- **Shift-register load** (at `cs_fall` and at every byte completion):
  - Holding register full: `tx_sh` <= holding; holding marked empty.
  - Holding register empty: `tx_sh` <= `IDLE_FILL` (8'hFF); `err_underrun` set.
- **Holding register:**
  - `tx_ready` = !`hold_full`, registered.
  - A write arriving in the same cycle as a load from an empty holding register is accepted into the holding register. The load still uses `IDLE_FILL`.
  - A load from a full holding register empties it; `tx_ready` rises the following cycle.
- **Receive side:**
  - `rx_valid` stays high until `rx_ack`.
  - A byte completing while `rx_valid`=1 and `rx_ack`=0 overwrites `rx_data` and sets `err_overrun`.
  - `rx_ack` in the same cycle as a completion: the new byte is taken, `rx_valid` stays 1, no overrun.
- **`err_clear` vs. a setting event** in the same cycle: the set wins.

## Timing
- **Reset values:**
  - `spi_miso`=0, `tx_ready`=1, `rx_data`=8'h00, `rx_valid`=0, `busy`=0, all `err_*`=0.
  - State IDLE; synchronizer chains set to idle levels (`spi_clk` 0, `spi_cs_n` 1).
- **Reset mid-frame:** aborts immediately with no flag. The target resumes only after a fresh `cs_fall`.
- **Edge-detect latency:** pin edge → pulse = `SYNC_STAGES`+1 clk cycles. `spi_miso` updates one cycle later, i.e. `SYNC_STAGES`+2 cycles after a rising pin edge.
- **`rx_valid`:** rises `SYNC_STAGES`+2 cycles after the 8th falling SCLK edge at the pin.
- **Master constraint:** each SCLK half-period must be ≥ `SYNC_STAGES`+3 clk cycles. For the on-chip master sharing `clk` this means divider ≥ `SYNC_STAGES`+2 (≥4 at default).
- **CS setup:** CS_N must fall ≥ `SYNC_STAGES`+2 cycles before the first SCLK rise.

## Configuration
- **`SPI_TARGET_ERR_FLAGS_EN` defined:** the three sticky flags and the `err_clear` logic are present as described above.
- **Undefined:**
  - `err_overrun`, `err_underrun` and `err_abort` are tied 0; `err_clear` is ignored.
  - Data-path behaviour is unchanged: overwrite, `IDLE_FILL` and partial-byte discard all still occur.

## Structure
- **Shared package:**
  - Holds the state encoding (IDLE=1'b0, ACTIVE=1'b1) and `IDLE_FILL`=8'hFF.
  - The on-chip master testbench reuses `IDLE_FILL`.
- **One sub-module:**
  - `spi_pin_sync`: parameterized `SYNC_STAGES` synchronizer plus history flop, producing level, rise and fall outputs.
  - Instantiated three times.

## Test plan
- **Single byte:** preload `tx_data`=8'hA5, CS low, master sends 8'h3C at divider 4 → master reads 8'hA5; `rx_data`=8'h3C; `rx_valid` 1 until `rx_ack`; `tx_ready` back to 1.
- **Back-to-back:** 3 bytes in one frame, MOSI 8'h01/8'h80/8'hFF; hold refilled with 8'h11/8'h22/8'h33 → master reads 8'h11/8'h22/8'h33; three `rx_valid` events.
- **Underrun and overrun:** no `tx_valid`, 2 bytes sent, no `rx_ack` → master reads 8'hFF twice; `rx_data`=second byte; `err_underrun`=`err_overrun`=1; `err_clear` → both 0.
- **Abort:** CS rises after 5 bits → `rx_valid` unchanged; `err_abort`=1. The next full frame sending 8'h5A is received correctly.
- **Reset mid-frame:** `rst` pulsed after 3 bits → all outputs at reset values next cycle; a subsequent frame is received correctly.
- **Simultaneous events:** `rx_ack` in the completion cycle → no overrun. `tx_valid` in the load cycle with hold empty → that byte goes out in the next byte slot.
